// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for the mips32 core: DM has fixed priority over IF, with a starvation guard for IF.
// Optional stall performance counters are built when MIPS_ARB_PERF_EN is defined.
module mips32_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          halted,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
`ifdef MIPS_ARB_PERF_EN
    ,
    output logic [31:0]   if_stall_cnt,
    output logic [31:0]   dm_stall_cnt
`endif
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    if (MEM_LAT < 1) begin : g_bad_lat
        $error("mips32_mem_arbiter: MEM_LAT must be at least 1");
    end

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_dm_q, owner_dm_d;
    logic          acc_we_q, acc_we_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
    logic          if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;

    logic          if_elig_s, pick_if_s, pick_dm_s;

    // IF wins when DM is absent, or when it has lost STARVE_MAX ties in a row
    assign if_elig_s = if_req & ~halted;
    assign pick_if_s = if_elig_s & (~dm_req | (starve_q == SW'(STARVE_MAX)));
    assign pick_dm_s = dm_req & ~pick_if_s;

    // State register and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_dm_q  <= 1'b0;
            acc_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_dm_q  <= owner_dm_d;
            acc_we_q    <= acc_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_gnt_q    <= if_gnt_d;
            dm_gnt_q    <= dm_gnt_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    // Arbitration, access sequencing and completion capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_dm_d  = owner_dm_q;
        acc_we_d    = acc_we_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        dm_gnt_d    = 1'b0;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_if_s || pick_dm_s) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = CW'(MEM_LAT - 1);
                    owner_dm_d  = pick_dm_s;
                    acc_we_d    = pick_dm_s & dm_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick_dm_s & dm_we;
                    mem_addr_d  = pick_dm_s ? dm_addr : if_addr;
                    mem_wdata_d = pick_dm_s ? dm_wdata : '0;
                    if_gnt_d    = pick_if_s;
                    dm_gnt_d    = pick_dm_s;
                    if (pick_if_s) begin
                        starve_d = '0;
                    end else if (if_elig_s && (starve_q != SW'(STARVE_MAX))) begin
                        starve_d = starve_q + SW'(1);
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    mem_en_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (owner_dm_q) begin
                        dm_valid_d = 1'b1;
                        if (!acc_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = dm_rdata_q;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef MIPS_ARB_PERF_EN
    logic [31:0] if_stall_q, dm_stall_q;
    logic        if_stall_s, dm_stall_s;

    // A halted core is not stalled on fetch, so those cycles are excluded
    assign if_stall_s = if_req & ~halted & ~((state_q == ST_IDLE) & pick_if_s)
                      & ~((state_q == ST_ACCESS) & ~owner_dm_q);
    assign dm_stall_s = dm_req & ~((state_q == ST_IDLE) & pick_dm_s)
                      & ~((state_q == ST_ACCESS) & owner_dm_q);

    // Saturating stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_stall_q <= 32'd0;
            dm_stall_q <= 32'd0;
        end else begin
            if (if_stall_s && (if_stall_q != 32'hFFFF_FFFF)) begin
                if_stall_q <= if_stall_q + 32'd1;
            end
            if (dm_stall_s && (dm_stall_q != 32'hFFFF_FFFF)) begin
                dm_stall_q <= dm_stall_q + 32'd1;
            end
        end
    end

    assign if_stall_cnt = if_stall_q;
    assign dm_stall_cnt = dm_stall_q;
`endif

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Self-checking bench for mips32_mem_arbiter: directed sequences, a vector table and
// randomized traffic checked against a transaction-level reference model.
module tb_mips32_mem_arbiter;

    localparam int NR = 800;
    localparam int LAT = 1;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted = 1'b0;

    logic        if_req, if_gnt, if_valid, dm_req, dm_we, dm_gnt, dm_valid;
    logic [9:0]  if_addr, dm_addr, mem_addr;
    logic [31:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we, busy;

    logic        if_req_3, if_gnt_3, if_valid_3, dm_req_3, dm_we_3, dm_gnt_3, dm_valid_3;
    logic [9:0]  if_addr_3, dm_addr_3, mem_addr_3;
    logic [31:0] if_rdata_3, dm_wdata_3, dm_rdata_3, mem_wdata_3, mem_rdata_3;
    logic        mem_en_3, mem_we_3, busy_3;

    logic [31:0] mem     [0:1023];
    logic [31:0] mem3    [0:1023];
    logic [31:0] ref_mem [0:1023];

    int n_pass = 0;
    int n_total = 0;

    mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mips32_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_MAX(SM)) dut3 (
        .clk(clk), .rst_n(rst_n), .halted(halted),
        .if_req(if_req_3), .if_addr(if_addr_3), .if_gnt(if_gnt_3), .if_valid(if_valid_3), .if_rdata(if_rdata_3),
        .dm_req(dm_req_3), .dm_we(dm_we_3), .dm_addr(dm_addr_3), .dm_wdata(dm_wdata_3),
        .dm_gnt(dm_gnt_3), .dm_valid(dm_valid_3), .dm_rdata(dm_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .busy(busy_3)
    );

    always #5 clk = ~clk;

    assign mem_rdata   = mem[mem_addr];
    assign mem_rdata_3 = mem3[mem_addr_3];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    end

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; halted = 1'b0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        if_req_3 = 1'b0; if_addr_3 = '0; dm_req_3 = 1'b0; dm_we_3 = 1'b0; dm_addr_3 = '0; dm_wdata_3 = '0;
        step();
        step();
    endtask

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_we_cycles;
    } vec_t;

    vec_t tbl [6];

    // random-phase expectation tables, indexed by cycle
    bit          e_ig [0:NR+7];
    bit          e_dg [0:NR+7];
    bit          e_iv [0:NR+7];
    bit          e_dv [0:NR+7];
    bit          e_dwr [0:NR+7];
    bit          e_busy [0:NR+7];
    bit          e_we [0:NR+7];
    logic [31:0] e_ivd [0:NR+7];
    logic [31:0] e_dvd [0:NR+7];

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt_a, cnt_b, cnt_c, vcyc, wecnt, other, ng;
        bit got;
        logic [5:0] order;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
            mem3[i] = 32'h3C000000 | 32'(i);
        end
        mem[3] = 32'h28030019;
        ref_mem[3] = 32'h28030019;

        tbl[0] = '{1'b1, 1'b1, 10'd10, 32'h00000037, init_word(5), 1};
        tbl[1] = '{1'b0, 1'b0, 10'd10, 32'h0, 32'h00000037, 0};
        tbl[2] = '{1'b1, 1'b0, 10'd10, 32'h0, 32'h00000037, 0};
        tbl[3] = '{1'b1, 1'b1, 10'd20, 32'hDEADBEEF, 32'h00000037, 1};
        tbl[4] = '{1'b1, 1'b0, 10'd20, 32'h0, 32'hDEADBEEF, 0};
        tbl[5] = '{1'b0, 1'b0, 10'd3, 32'h0, 32'h28030019, 0};

        // reset state
        apply_reset();
        check("rst_if_gnt", if_gnt, 1'b0);
        check("rst_dm_gnt", dm_gnt, 1'b0);
        check("rst_valids", {if_valid, dm_valid}, 2'b00);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_mem", {mem_en, mem_we, busy}, 3'b000);
        check("rst_mem_addr", mem_addr, 10'd0);
        rst_n = 1'b1;

        // single fetch timing
        if_req = 1'b1; if_addr = 10'd3;
        step();
        check("t1_if_gnt", if_gnt, 1'b1);
        check("t1_dm_gnt", dm_gnt, 1'b0);
        check("t1_mem_en", mem_en, 1'b1);
        check("t1_mem_addr", mem_addr, 10'd3);
        check("t1_busy", busy, 1'b1);
        if_req = 1'b0;
        step();
        check("t1_if_valid", if_valid, 1'b1);
        check("t1_if_rdata", if_rdata, 32'h28030019);
        check("t1_idle", {mem_en, busy, if_gnt}, 3'b000);
        check("t1_mem_addr0", mem_addr, 10'd0);

        // simultaneous IF and DM requests
        step();
        if_req = 1'b1; if_addr = 10'd0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd5;
        step();
        check("t2_gnts_c1", {dm_gnt, if_gnt}, 2'b10);
        dm_req = 1'b0;
        step();
        check("t2_dm_valid", dm_valid, 1'b1);
        check("t2_dm_rdata", dm_rdata, init_word(5));
        check("t2_if_gnt_c2", if_gnt, 1'b0);
        step();
        check("t2_if_gnt_c3", if_gnt, 1'b1);
        check("t2_mem_addr_c3", mem_addr, 10'd0);
        if_req = 1'b0;
        step();
        check("t2_if_valid_c4", if_valid, 1'b1);
        check("t2_if_rdata", if_rdata, init_word(0));

        // vector table: back-to-back single transactions
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].is_dm) begin
                dm_req = 1'b1; dm_we = tbl[i].we; dm_addr = tbl[i].addr; dm_wdata = tbl[i].wdata;
                if (tbl[i].we) ref_mem[tbl[i].addr] = tbl[i].wdata;
            end else begin
                if_req = 1'b1; if_addr = tbl[i].addr;
            end
            got = 1'b0; wecnt = 0; other = 0;
            for (int c = 0; c < 16; c++) begin
                step();
                if (mem_we) wecnt++;
                if (tbl[i].is_dm ? (if_gnt | if_valid) : (dm_gnt | dm_valid)) other++;
                if (tbl[i].is_dm ? dm_gnt : if_gnt) begin
                    dm_req = 1'b0; if_req = 1'b0;
                end
                if (tbl[i].is_dm ? dm_valid : if_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            check($sformatf("tbl%0d_valid", i), got, 1'b1);
            check($sformatf("tbl%0d_rdata", i), tbl[i].is_dm ? dm_rdata : if_rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_we_cycles", i), wecnt, tbl[i].exp_we_cycles);
            check($sformatf("tbl%0d_other_port", i), other, 0);
            dm_req = 1'b0; if_req = 1'b0;
        end

        // starvation guard with both requests held high
        apply_reset();
        rst_n = 1'b1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd1;
        if_req = 1'b1; if_addr = 10'd2;
        order = '0; ng = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            step();
            if (if_gnt && dm_gnt) check("t4_both_gnt", 2'b11, 2'b01);
            if (if_gnt || dm_gnt) begin
                order = {order[4:0], dm_gnt};
                ng++;
            end
        end
        check("t4_grant_count", ng, 6);
        check("t4_grant_order", order, 6'b111101);
        dm_req = 1'b0; if_req = 1'b0;

        // halted blocks IF only
        apply_reset();
        rst_n = 1'b1;
        halted = 1'b1;
        if_req = 1'b1; if_addr = 10'd4;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd6;
            end
            step();
            if (if_gnt) cnt_a++;
            if (dm_gnt) begin
                cnt_b++;
                dm_req = 1'b0;
            end
            if (dm_valid) begin
                cnt_c++;
                check("t5_dm_rdata", dm_rdata, init_word(6));
            end
        end
        check("t5_no_if_gnt", cnt_a, 0);
        check("t5_dm_gnt_count", cnt_b, 1);
        check("t5_dm_valid_count", cnt_c, 1);
        halted = 1'b0;
        step();
        check("t5_if_gnt_after_halt", if_gnt, 1'b1);
        if_req = 1'b0;
        step();
        check("t5_if_valid", if_valid, 1'b1);
        check("t5_if_rdata", if_rdata, init_word(4));

        // reset in the middle of a MEM_LAT=3 access
        apply_reset();
        rst_n = 1'b1;
        if_req_3 = 1'b1; if_addr_3 = 10'd7;
        step();
        check("t6_if_gnt", if_gnt_3, 1'b1);
        check("t6_busy_c1", busy_3, 1'b1);
        if_req_3 = 1'b0;
        step();
        check("t6_busy_c2", {busy_3, mem_en_3}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("t6_rst_immediate", {busy_3, mem_en_3}, 2'b00);
        step();
        step();
        rst_n = 1'b1;
        cnt_a = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (if_valid_3 || dm_valid_3) cnt_a++;
        end
        check("t6_no_valid_after_rst", cnt_a, 0);
        dm_req_3 = 1'b1; dm_we_3 = 1'b0; dm_addr_3 = 10'd9;
        vcyc = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (dm_gnt_3) begin
                check("t6_dm_gnt_cycle", c, 1);
                dm_req_3 = 1'b0;
            end
            if (dm_valid_3) begin
                vcyc = c;
                check("t6_dm_rdata", dm_rdata_3, 32'h3C000009);
                break;
            end
        end
        check("t6_dm_valid_cycle", vcyc, 4);

        // randomized traffic against transaction-level model
        apply_reset();
        rst_n = 1'b1;
        for (int k = 0; k < NR + 8; k++) begin
            e_ig[k] = 0; e_dg[k] = 0; e_iv[k] = 0; e_dv[k] = 0; e_dwr[k] = 0;
            e_busy[k] = 0; e_we[k] = 0; e_ivd[k] = '0; e_dvd[k] = '0;
        end
        begin
            int free_at, starve;
            bit if_out, dm_out, ie, de;
            logic [31:0] hold_i, hold_d;
            free_at = 0; starve = 0; if_out = 0; dm_out = 0;
            hold_i = '0; hold_d = '0;
            for (int k = 0; k < NR; k++) begin
                if (e_iv[k]) hold_i = e_ivd[k];
                if (e_dv[k] && !e_dwr[k]) hold_d = e_dvd[k];
                check("r_if_gnt", if_gnt, e_ig[k]);
                check("r_dm_gnt", dm_gnt, e_dg[k]);
                check("r_if_valid", if_valid, e_iv[k]);
                check("r_dm_valid", dm_valid, e_dv[k]);
                check("r_if_rdata", if_rdata, hold_i);
                check("r_dm_rdata", dm_rdata, hold_d);
                check("r_busy", {busy, mem_en}, {e_busy[k], e_busy[k]});
                check("r_mem_we", mem_we, e_we[k]);

                if (if_gnt) if_req = 1'b0;
                if (if_valid) if_out = 0;
                if (dm_gnt) dm_req = 1'b0;
                if (dm_valid) dm_out = 0;
                if (!if_out && $urandom_range(0, 2) == 0) begin
                    if_req = 1'b1; if_addr = 10'($urandom_range(0, 15)); if_out = 1;
                end
                if (!dm_out && $urandom_range(0, 2) == 0) begin
                    dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                    dm_addr = 10'($urandom_range(0, 15)); dm_wdata = $urandom; dm_out = 1;
                end
                if ($urandom_range(0, 9) == 0) halted = ~halted;

                if (k >= free_at) begin
                    ie = if_req && !halted;
                    de = dm_req;
                    if (ie || de) begin
                        if (ie && (!de || starve == SM)) begin
                            starve = 0;
                            e_ig[k+1] = 1;
                            e_iv[k+1+LAT] = 1;
                            e_ivd[k+1+LAT] = ref_mem[if_addr];
                        end else begin
                            if (ie && starve < SM) starve++;
                            e_dg[k+1] = 1;
                            e_dv[k+1+LAT] = 1;
                            if (dm_we) begin
                                ref_mem[dm_addr] = dm_wdata;
                                e_we[k+1] = 1;
                                e_dwr[k+1+LAT] = 1;
                            end else begin
                                e_dvd[k+1+LAT] = ref_mem[dm_addr];
                            end
                        end
                        for (int j = 1; j <= LAT; j++) e_busy[k+j] = 1;
                        free_at = k + 1 + LAT;
                    end
                end
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
